// File: rtl/seq_decoder.sv
// seq_decoder: registered one-hot decoder with direct-select and auto-scan modes
// Ports: clk (rising edge), rst_n (sync, active-low), en (enable), mode (0 direct / 1 scan),
//   sel/sel_valid/sel_ready (select handshake), dwell (extra cycles per scan position),
//   y (one-hot or zero), y_valid, scan_wrap (pulse on scan wrap-around),
//   err (pulse on out-of-range select, only with SEQ_DECODER_ERR_EN defined)
module seq_decoder #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
`ifdef SEQ_DECODER_ERR_EN
  output logic               scan_wrap,
  output logic               err
`else
  output logic               scan_wrap
`endif
);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t r_state, w_state_n, w_tgt;
  logic [NUM_OUT-1:0] r_y, w_y_n, w_dec;
  logic [DWELL_W-1:0] r_cnt, w_cnt_n;
  logic r_y_valid, w_y_valid_n, r_wrap, w_wrap_n, w_in_range;
`ifdef SEQ_DECODER_ERR_EN
  logic r_err, w_err_n;
  assign err = r_err;
`endif
  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign scan_wrap = r_wrap;
  // a mode mismatch or disable blocks the handshake in the same cycle
  assign sel_ready = (r_state == DIRECT) && en && !mode;
  assign w_in_range = {1'b0, sel} < (SEL_W+1)'(NUM_OUT);
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) w_dec[i] = (sel == SEL_W'(i));
  end
  always_comb begin
    w_state_n   = r_state;
    w_y_n       = r_y;
    w_y_valid_n = r_y_valid;
    w_cnt_n     = r_cnt;
    w_wrap_n    = 1'b0;
`ifdef SEQ_DECODER_ERR_EN
    w_err_n     = 1'b0;
`endif
    w_tgt = mode ? SCAN : DIRECT;
    if (!en || (r_state != IDLE && r_state != w_tgt)) begin
      w_state_n   = IDLE;
      w_y_n       = '0;
      w_y_valid_n = 1'b0;
      w_cnt_n     = '0;
    end else if (r_state == IDLE) begin
      w_state_n = w_tgt;
      if (mode) begin
        w_y_n       = NUM_OUT'(1);
        w_y_valid_n = 1'b1;
        w_cnt_n     = dwell;
      end
    end else if (r_state == DIRECT) begin
      if (sel_valid) begin
        w_y_n       = w_in_range ? w_dec : '0;
        w_y_valid_n = 1'b1;
`ifdef SEQ_DECODER_ERR_EN
        w_err_n     = !w_in_range;
`endif
      end
    end else if (r_cnt == '0) begin
      // rotating the one-hot keeps at most one bit set by construction
      w_y_n    = {r_y[NUM_OUT-2:0], r_y[NUM_OUT-1]};
      w_cnt_n  = dwell;
      w_wrap_n = r_y[NUM_OUT-1];
    end else begin
      w_cnt_n = r_cnt - DWELL_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
`ifdef SEQ_DECODER_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_y       <= w_y_n;
      r_y_valid <= w_y_valid_n;
      r_cnt     <= w_cnt_n;
      r_wrap    <= w_wrap_n;
`ifdef SEQ_DECODER_ERR_EN
      r_err     <= w_err_n;
`endif
    end
  end
endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: scoreboard bench for seq_decoder at NUM_OUT = 8, 6 and 4
module tb_seq_decoder;
  logic clk = 1'b0;
  logic rst_n, en, mode, sel_valid;
  logic [2:0] sel;
  logic [3:0] dwell;
  logic [7:0] y8;
  logic [5:0] y6;
  logic [3:0] y4;
  logic yv8, yv6, yv4, rdy8, rdy6, rdy4, wr8, wr6, wr4;
`ifdef SEQ_DECODER_ERR_EN
  logic err8, err6, err4;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct {logic [7:0] y; logic v; logic w; logic e;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  seq_decoder #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy8), .dwell(dwell), .y(y8), .y_valid(yv8),
`ifdef SEQ_DECODER_ERR_EN
    .scan_wrap(wr8), .err(err8)
`else
    .scan_wrap(wr8)
`endif
  );
  seq_decoder #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy6), .dwell(dwell), .y(y6), .y_valid(yv6),
`ifdef SEQ_DECODER_ERR_EN
    .scan_wrap(wr6), .err(err6)
`else
    .scan_wrap(wr6)
`endif
  );
  seq_decoder #(.SEL_W(3), .NUM_OUT(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy4), .dwell(dwell), .y(y4), .y_valid(yv4),
`ifdef SEQ_DECODER_ERR_EN
    .scan_wrap(wr4), .err(err4)
`else
    .scan_wrap(wr4)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    sel_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel_valid = 1'b1; sel = 3'd5; dwell = 4'd0;
    cyc();
    cyc();
    checks++;
    if (y8 !== 8'h00 || yv8 !== 1'b0 || wr8 !== 1'b0 || rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8 y=%b v=%b w=%b rdy=%b expected all zero", y8, yv8, wr8, rdy8);
    end
    checks++;
    if (y6 !== 6'h00 || yv6 !== 1'b0 || y4 !== 4'h0 || yv4 !== 1'b0) begin
      errors++;
      $display("FAIL reset64 y6=%b v6=%b y4=%b v4=%b expected all zero", y6, yv6, y4, yv4);
    end
`ifdef SEQ_DECODER_ERR_EN
    checks++;
    if (err6 !== 1'b0) begin
      errors++;
      $display("FAIL reset_err err=%b expected 0", err6);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [2:0] s [5] = '{3'd5, 3'd0, 3'd7, 3'd3, 3'd1};
    go_idle();
    en = 1'b1; mode = 1'b0;
    cyc();
    checks++;
    if (y8 !== 8'h00 || yv8 !== 1'b0) begin
      errors++;
      $display("FAIL direct_entry y=%b v=%b expected 00000000 0", y8, yv8);
    end
    // back-to-back transfers with sel_valid held high
    for (int i = 0; i < 5; i++) begin
      sel_valid = 1'b1; sel = s[i];
      #1;
      checks++;
      if (rdy8 !== 1'b1) begin
        errors++;
        $display("FAIL direct_ready rdy=%b expected 1", rdy8);
      end
      q.push_back('{y: 8'h01 << s[i], v: 1'b1, w: 1'b0, e: 1'b0});
      cyc();
      e = q.pop_front();
      checks++;
      if (y8 !== e.y || yv8 !== e.v || wr8 !== e.w) begin
        errors++;
        $display("FAIL direct sel=%0d y=%b v=%b w=%b expected y=%b v=%b w=%b", s[i], y8, yv8, wr8, e.y, e.v, e.w);
      end
    end
    sel_valid = 1'b0; sel = 3'd6;
    for (int i = 0; i < 2; i++) begin
      q.push_back('{y: 8'b0000_0010, v: 1'b1, w: 1'b0, e: 1'b0});
      cyc();
      e = q.pop_front();
      checks++;
      if (y8 !== e.y || yv8 !== e.v) begin
        errors++;
        $display("FAIL direct_hold y=%b v=%b expected y=%b v=%b", y8, yv8, e.y, e.v);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] s [4] = '{3'd7, 3'd2, 3'd6, 3'd5};
    logic [5:0] ey [4] = '{6'b000000, 6'b000100, 6'b000000, 6'b100000};
    go_idle();
    en = 1'b1; mode = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      // the last step offers nothing: y holds and err must have dropped
      sel_valid = (i < 4);
      sel = (i < 4) ? s[i] : 3'd7;
      q.push_back('{y: {2'b00, ey[(i < 4) ? i : 3]}, v: 1'b1, w: 1'b0, e: (i < 4) && s[i] >= 3'd6});
      cyc();
      e = q.pop_front();
      checks++;
      if (y6 !== e.y[5:0] || yv6 !== e.v) begin
        errors++;
        $display("FAIL range step=%0d y=%b v=%b expected y=%b v=%b", i, y6, yv6, e.y[5:0], e.v);
      end
`ifdef SEQ_DECODER_ERR_EN
      checks++;
      if (err6 !== e.e) begin
        errors++;
        $display("FAIL range_err step=%0d err=%b expected %b", i, err6, e.e);
      end
`endif
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] ey [19] = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8, 1, 1, 1, 2, 4, 8, 1};
    go_idle();
    en = 1'b1; mode = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      // dwell drops to 0 after the wrap; it only takes effect at the next position change
      dwell = (c <= 13) ? 4'd2 : 4'd0;
      q.push_back('{y: {4'h0, ey[c-1]}, v: 1'b1, w: (c == 13) || (c == 19), e: 1'b0});
      cyc();
      e = q.pop_front();
      checks++;
      if (y4 !== e.y[3:0] || yv4 !== e.v || wr4 !== e.w || rdy4 !== 1'b0) begin
        errors++;
        $display("FAIL scan cycle=%0d y=%b v=%b w=%b rdy=%b expected y=%b v=%b w=%b rdy=0", c, y4, yv4, wr4, rdy4, e.y[3:0], e.v, e.w);
      end
    end
  endtask

  task automatic test_mode_switch();
    go_idle();
    en = 1'b1; mode = 1'b0;
    cyc();
    sel_valid = 1'b1; sel = 3'd3;
    q.push_back('{y: 8'b0000_1000, v: 1'b1, w: 1'b0, e: 1'b0});
    cyc();
    sel_valid = 1'b0; mode = 1'b1;
    #1;
    checks++;
    if (rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL switch_ready rdy=%b expected 0", rdy8);
    end
    q.push_back('{y: 8'h00, v: 1'b0, w: 1'b0, e: 1'b0});
    q.push_back('{y: 8'h01, v: 1'b1, w: 1'b0, e: 1'b0});
    e = q.pop_front();
    checks++;
    if (y8 !== e.y || yv8 !== e.v) begin
      errors++;
      $display("FAIL switch_direct y=%b v=%b expected y=%b v=%b", y8, yv8, e.y, e.v);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = q.pop_front();
      checks++;
      if (y8 !== e.y || yv8 !== e.v || wr8 !== e.w) begin
        errors++;
        $display("FAIL switch step=%0d y=%b v=%b w=%b expected y=%b v=%b w=%b", i, y8, yv8, wr8, e.y, e.v, e.w);
      end
    end
    mode = 1'b0;
    q.push_back('{y: 8'h00, v: 1'b0, w: 1'b0, e: 1'b0});
    q.push_back('{y: 8'h00, v: 1'b0, w: 1'b0, e: 1'b0});
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = q.pop_front();
      checks++;
      if (y8 !== e.y || yv8 !== e.v || rdy8 !== (i == 1)) begin
        errors++;
        $display("FAIL switch_back step=%0d y=%b v=%b rdy=%b expected y=%b v=%b rdy=%b", i, y8, yv8, rdy8, e.y, e.v, i == 1);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    go_idle();
    en = 1'b1; mode = 1'b1; dwell = 4'd0;
    for (int i = 0; i < 7; i++) q.push_back('{y: 8'h01 << i, v: 1'b1, w: 1'b0, e: 1'b0});
    q.push_back('{y: 8'h00, v: 1'b0, w: 1'b0, e: 1'b0});
    q.push_back('{y: 8'h01, v: 1'b1, w: 1'b0, e: 1'b0});
    q.push_back('{y: 8'h02, v: 1'b1, w: 1'b0, e: 1'b0});
    for (int i = 0; i < 10; i++) begin
      rst_n = (i != 7);
      cyc();
      e = q.pop_front();
      checks++;
      if (y8 !== e.y || yv8 !== e.v || wr8 !== e.w) begin
        errors++;
        $display("FAIL rst_scan step=%0d y=%b v=%b w=%b expected y=%b v=%b w=%b", i, y8, yv8, wr8, e.y, e.v, e.w);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_disable();
    go_idle();
    en = 1'b1; mode = 1'b0;
    cyc();
    sel_valid = 1'b1; sel = 3'd2;
    q.push_back('{y: 8'b0000_0100, v: 1'b1, w: 1'b0, e: 1'b0});
    cyc();
    e = q.pop_front();
    checks++;
    if (y8 !== e.y || yv8 !== e.v) begin
      errors++;
      $display("FAIL disable_pre y=%b v=%b expected y=%b v=%b", y8, yv8, e.y, e.v);
    end
    en = 1'b0; sel = 3'd6;
    #1;
    checks++;
    if (rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL disable_ready rdy=%b expected 0", rdy8);
    end
    q.push_back('{y: 8'h00, v: 1'b0, w: 1'b0, e: 1'b0});
    cyc();
    e = q.pop_front();
    checks++;
    if (y8 !== e.y || yv8 !== e.v || rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL disable y=%b v=%b rdy=%b expected y=%b v=%b rdy=0", y8, yv8, rdy8, e.y, e.v);
    end
    sel_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_scan();
    test_mode_switch();
    test_reset_mid_scan();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
